// File: rtl/phase_step_monitor.sv
// Stepper coil phase monitor: deglitches H-bridge leg drives into a signed
// full-step position with skip/short detection, and measures VREF PWM duty.
module phase_step_monitor #(
   parameter int unsigned GLITCH_CYCLES = 4,
   parameter int unsigned PWM_WINDOW    = 256,
   parameter int unsigned COUNT_W       = 32,
   localparam int unsigned DUTY_W       = $clog2(PWM_WINDOW) + 1
) (
   input  logic               CLK,
   input  logic               resetn_in,
   input  logic               PHASE_A1,
   input  logic               PHASE_A2,
   input  logic               PHASE_B1,
   input  logic               PHASE_B2,
   input  logic               VREF_A,
   input  logic               VREF_B,
   input  logic               clr_flags,
   output logic [COUNT_W-1:0] step_count,
   output logic               step_pulse,
   output logic               dir,
   output logic               skip_err,
   output logic               fault,
   output logic [DUTY_W-1:0]  duty_a,
   output logic [DUTY_W-1:0]  duty_b,
   output logic               duty_valid
);

   localparam int unsigned WIN_W = $clog2(PWM_WINDOW);
   localparam int unsigned RUN_W = 4;

   typedef enum logic [1:0] {C_OFF = 2'b00, C_NEG = 2'b01, C_POS = 2'b10, C_SHORT = 2'b11} coil_t;
   typedef enum logic {INIT, TRACK} state_t;

   logic [5:0]       sync1, sync2;
   logic [3:0]       code, cand, acc_code;
   logic [RUN_W-1:0] run_cnt, run_nxt;
   logic             accept, acc_new;

   always_ff @(posedge CLK or negedge resetn_in) begin
      if (!resetn_in) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {PHASE_A1, PHASE_A2, PHASE_B1, PHASE_B2, VREF_A, VREF_B};
         sync2 <= sync1;
      end
   end

   // run_nxt counts consecutive clocks (including this one) that code has held
   assign code = sync2[5:2];

   always_comb begin
      if (code == cand)
         run_nxt = (run_cnt == RUN_W'(GLITCH_CYCLES)) ? run_cnt : run_cnt + RUN_W'(1);
      else
         run_nxt = RUN_W'(1);
      accept = (run_nxt == RUN_W'(GLITCH_CYCLES)) && (code != acc_code);
   end

   always_ff @(posedge CLK or negedge resetn_in) begin
      if (!resetn_in) begin
         cand     <= '0;
         run_cnt  <= '0;
         acc_code <= '0;
         acc_new  <= 1'b0;
      end else begin
         cand    <= code;
         run_cnt <= run_nxt;
         acc_new <= accept;
         if (accept) acc_code <= code;
      end
   end

   coil_t        coil_a, coil_b;
   logic         has_q;
   logic [1:0]   q, d;
   state_t       state, state_nxt;
   logic [1:0]   quad, quad_nxt;
   logic [COUNT_W-1:0] count_nxt;
   logic         dir_nxt, pulse_nxt, skip_set, fault_set, skip_nxt, fault_nxt;

   assign coil_a = coil_t'(acc_code[3:2]);
   assign coil_b = coil_t'(acc_code[1:0]);

   always_comb begin
      has_q = 1'b1;
      q     = 2'd0;
      case ({coil_a, coil_b})
         {C_POS, C_POS}: q = 2'd0;
         {C_NEG, C_POS}: q = 2'd1;
         {C_NEG, C_NEG}: q = 2'd2;
         {C_POS, C_NEG}: q = 2'd3;
         default:        has_q = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      quad_nxt  = quad;
      count_nxt = step_count;
      dir_nxt   = dir;
      pulse_nxt = 1'b0;
      skip_set  = 1'b0;
      fault_set = acc_new && (coil_a == C_SHORT || coil_b == C_SHORT);
      d         = q - quad;
      if (acc_new && has_q) begin
         quad_nxt = q;
         case (state)
            INIT: state_nxt = TRACK;
            TRACK: begin
               case (d)
                  2'd1: begin
                     count_nxt = step_count + COUNT_W'(1);
                     dir_nxt   = 1'b1;
                     pulse_nxt = 1'b1;
                  end
                  2'd3: begin
                     count_nxt = step_count - COUNT_W'(1);
                     dir_nxt   = 1'b0;
                     pulse_nxt = 1'b1;
                  end
                  2'd2:    skip_set = 1'b1;
                  default: ;
               endcase
            end
            default: state_nxt = INIT;
         endcase
      end
      // a flag set in the same clock as clr_flags survives the clear
      skip_nxt  = skip_set  | (skip_err & ~clr_flags);
      fault_nxt = fault_set | (fault & ~clr_flags);
   end

   always_ff @(posedge CLK or negedge resetn_in) begin
      if (!resetn_in) begin
         state      <= INIT;
         quad       <= '0;
         step_count <= '0;
         dir        <= 1'b0;
         step_pulse <= 1'b0;
         skip_err   <= 1'b0;
         fault      <= 1'b0;
      end else begin
         state      <= state_nxt;
         quad       <= quad_nxt;
         step_count <= count_nxt;
         dir        <= dir_nxt;
         step_pulse <= pulse_nxt;
         skip_err   <= skip_nxt;
         fault      <= fault_nxt;
      end
   end

   logic [WIN_W-1:0]  win_cnt;
   logic [DUTY_W-1:0] hi_a, hi_b, sum_a, sum_b;
   logic              win_end;

   assign sum_a   = hi_a + DUTY_W'(sync2[1]);
   assign sum_b   = hi_b + DUTY_W'(sync2[0]);
   assign win_end = (win_cnt == WIN_W'(PWM_WINDOW - 1));

   always_ff @(posedge CLK or negedge resetn_in) begin
      if (!resetn_in) begin
         win_cnt    <= '0;
         hi_a       <= '0;
         hi_b       <= '0;
         duty_a     <= '0;
         duty_b     <= '0;
         duty_valid <= 1'b0;
      end else begin
         win_cnt    <= win_cnt + WIN_W'(1);
         duty_valid <= win_end;
         if (win_end) begin
            duty_a <= sum_a;
            duty_b <= sum_b;
            hi_a   <= '0;
            hi_b   <= '0;
         end else begin
            hi_a <= sum_a;
            hi_b <= sum_b;
         end
      end
   end

endmodule

// File: tb/tb_phase_step_monitor.sv
// Directed bench for phase_step_monitor: stepping, glitch filter, flags,
// duty measurement and asynchronous reset, with hand-computed expectations.
module tb_phase_step_monitor;

   logic        CLK = 1'b0;
   logic        resetn_in;
   logic        PHASE_A1, PHASE_A2, PHASE_B1, PHASE_B2, VREF_A, VREF_B, clr_flags;
   logic [31:0] step_count;
   logic        step_pulse, dir, skip_err, fault, duty_valid;
   logic [8:0]  duty_a, duty_b;

   int unsigned vecs = 0;
   int unsigned errs = 0;
   int unsigned pulse_cnt = 0;
   int unsigned nvalid;
   logic        duty_seen;

   phase_step_monitor #(.GLITCH_CYCLES(4), .PWM_WINDOW(256), .COUNT_W(32)) dut (
      .CLK(CLK), .resetn_in(resetn_in),
      .PHASE_A1(PHASE_A1), .PHASE_A2(PHASE_A2), .PHASE_B1(PHASE_B1), .PHASE_B2(PHASE_B2),
      .VREF_A(VREF_A), .VREF_B(VREF_B), .clr_flags(clr_flags),
      .step_count(step_count), .step_pulse(step_pulse), .dir(dir),
      .skip_err(skip_err), .fault(fault),
      .duty_a(duty_a), .duty_b(duty_b), .duty_valid(duty_valid)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
         if (step_pulse === 1'b1) pulse_cnt++;
      end
   endtask

   task automatic set_q(input int unsigned q);
      case (q)
         0:       {PHASE_A1, PHASE_A2, PHASE_B1, PHASE_B2} = 4'b1010;
         1:       {PHASE_A1, PHASE_A2, PHASE_B1, PHASE_B2} = 4'b0110;
         2:       {PHASE_A1, PHASE_A2, PHASE_B1, PHASE_B2} = 4'b0101;
         default: {PHASE_A1, PHASE_A2, PHASE_B1, PHASE_B2} = 4'b1001;
      endcase
   endtask

   initial begin
      resetn_in = 1'b0;
      {PHASE_A1, PHASE_A2, PHASE_B1, PHASE_B2} = 4'b0000;
      VREF_A = 1'b0; VREF_B = 1'b0; clr_flags = 1'b0;
      run(3);
      chk("rst_count", step_count, 0);
      chk("rst_dir",   dir, 0);
      chk("rst_pulse", step_pulse, 0);
      chk("rst_skip",  skip_err, 0);
      chk("rst_fault", fault, 0);
      chk("rst_duty_a", duty_a, 0);
      chk("rst_duty_b", duty_b, 0);
      chk("rst_dvalid", duty_valid, 0);

      // forward: 0 latches INIT, then 1,2,3,0
      resetn_in = 1'b1;
      pulse_cnt = 0;
      set_q(0); run(20);
      chk("init_count", step_count, 0);
      chk("init_pulses", pulse_cnt, 0);
      set_q(1); run(6);
      chk("lat_before", step_count, 0);
      run(1);
      chk("lat_count", step_count, 1);
      chk("lat_pulse", step_pulse, 1);
      run(13);
      set_q(2); run(20);
      set_q(3); run(20);
      set_q(0); run(20);
      chk("fwd_count",  step_count, 4);
      chk("fwd_dir",    dir, 1);
      chk("fwd_pulses", pulse_cnt, 4);
      chk("fwd_skip",   skip_err, 0);

      // reverse with wrap below zero
      resetn_in = 1'b0; run(2); resetn_in = 1'b1;
      set_q(0); run(20);
      pulse_cnt = 0;
      set_q(3); run(20);
      set_q(2); run(20);
      set_q(1); run(20);
      set_q(0); run(20);
      chk("rev_count",  step_count, 32'hFFFF_FFFC);
      chk("rev_dir",    dir, 0);
      chk("rev_pulses", pulse_cnt, 4);

      // glitch: coil A off, B NEG; an A1 pulse would make quadrant 3 (d=3)
      {PHASE_A1, PHASE_A2, PHASE_B1, PHASE_B2} = 4'b0001; run(20);
      pulse_cnt = 0;
      PHASE_A1 = 1'b1; run(3); PHASE_A1 = 1'b0; run(20);
      chk("glitch3_pulses", pulse_cnt, 0);
      chk("glitch3_count",  step_count, 32'hFFFF_FFFC);
      PHASE_A1 = 1'b1; run(6); PHASE_A1 = 1'b0; run(20);
      chk("glitch6_pulses", pulse_cnt, 1);
      chk("glitch6_count",  step_count, 32'hFFFF_FFFB);

      // skip, short fault, clear
      set_q(0); run(20);
      chk("pre_skip_count", step_count, 32'hFFFF_FFFC);
      pulse_cnt = 0;
      set_q(2); run(20);
      chk("skip_flag",   skip_err, 1);
      chk("skip_count",  step_count, 32'hFFFF_FFFC);
      chk("skip_pulses", pulse_cnt, 0);
      chk("skip_nofault", fault, 0);
      {PHASE_A1, PHASE_A2} = 2'b11; run(10);
      chk("fault_flag", fault, 1);
      set_q(2); run(20);
      clr_flags = 1'b1; run(1); clr_flags = 1'b0; run(1);
      chk("clr_skip",  skip_err, 0);
      chk("clr_fault", fault, 0);
      chk("clr_count", step_count, 32'hFFFF_FFFC);

      // duty: A 4-of-16 square, B held high; second duty_valid is a full window
      VREF_B = 1'b1; run(4);
      nvalid = 0;
      duty_seen = 1'b0;
      for (int unsigned i = 0; i < 1200 && !duty_seen; i++) begin
         VREF_A = ((i % 16) < 4);
         run(1);
         if (duty_valid === 1'b1) begin
            nvalid++;
            if (nvalid == 2) begin
               duty_seen = 1'b1;
               chk("duty_a", duty_a, 64);
               chk("duty_b", duty_b, 256);
            end
         end
      end
      chk("duty_window_seen", duty_seen, 1);
      VREF_A = 1'b0;

      // reset mid-move with a partially filtered quadrant 3
      set_q(3); run(4);
      resetn_in = 1'b0;
      #1;
      chk("mid_rst_count",  step_count, 0);
      chk("mid_rst_dir",    dir, 0);
      chk("mid_rst_pulse",  step_pulse, 0);
      chk("mid_rst_duty_a", duty_a, 0);
      chk("mid_rst_duty_b", duty_b, 0);
      run(3);
      resetn_in = 1'b1;
      pulse_cnt = 0;
      run(20);
      chk("post_rst_count",  step_count, 0);
      chk("post_rst_pulses", pulse_cnt, 0);
      set_q(0); run(20);
      chk("post_rst_step",   step_count, 1);
      chk("post_rst_dir",    dir, 1);
      chk("post_rst_pulse1", pulse_cnt, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/phase_step_monitor.md
PHASE_STEP_MONITOR -- requirements
Module: phase_step_monitor

Interface
REQ-001 SHALL have parameter GLITCH_CYCLES, default 4, meaning the number of consecutive clocks a new coil code must be stable before it is accepted (range 1..15).
REQ-002 SHALL have parameter PWM_WINDOW, default 256, meaning the duty measurement window in clocks (power of two, at least 4).
REQ-003 SHALL have parameter COUNT_W, default 32, meaning the width of step_count.
REQ-004 SHALL have port CLK, input, width 1: the single clock; every flop in the block is clocked on its rising edge.
REQ-005 SHALL have port resetn_in, input, width 1: reset, asynchronous and active-low.
REQ-006 SHALL have ports PHASE_A1, PHASE_A2, PHASE_B1, PHASE_B2, each input, width 1: H-bridge leg drives for coils A and B.
REQ-007 SHALL have ports VREF_A and VREF_B, each input, width 1: the PWM current-reference outputs.
REQ-008 SHALL have port clr_flags, input, width 1: a synchronous one-clock request that clears the sticky flags.
REQ-009 SHALL have port step_count, output, width COUNT_W: signed full-step position.
REQ-010 SHALL have ports step_pulse and dir, each output, width 1: step_pulse is a one-clock pulse per accepted step; dir is 1 for forward.
REQ-011 SHALL have ports skip_err and fault, each output, width 1: sticky flags.
REQ-012 SHALL have ports duty_a and duty_b, each output, width log2(PWM_WINDOW)+1: the high-clock counts from the last completed window.
REQ-013 SHALL have port duty_valid, output, width 1: a one-clock pulse when duty_a and duty_b update.

Function
REQ-014 SHALL pass all six phase and VREF inputs through a 2-flop synchronizer before any use.
REQ-015 SHALL decode each coil from its synchronized legs as follows: leg1 high, leg2 low = POS; leg1 low, leg2 high = NEG; both low = OFF; both high = SHORT.
REQ-016 SHALL accept a changed {coilA, coilB} code only after it has been identical for GLITCH_CYCLES consecutive clocks; any change of the code within that period restarts the count.
REQ-017 SHALL, when the accepted code contains SHORT on either coil, set fault; fault stays set until clr_flags or reset.
REQ-018 SHALL map quadrants as follows: (POS,POS)=0, (NEG,POS)=1, (NEG,NEG)=2, (POS,NEG)=3; any code containing OFF or SHORT has no quadrant.
REQ-019 SHALL implement an FSM with states INIT and TRACK, reset into INIT.
REQ-020 SHALL, in INIT, latch the quadrant on the first accepted code that has a quadrant, move to TRACK, and change nothing in step_count.
REQ-021 SHALL, in TRACK, when an accepted code has quadrant q and the stored quadrant is p, compute d = (q - p) mod 4 and act as follows: d=1 -> step_count+1, dir=1, step_pulse; d=3 -> step_count-1, dir=0, step_pulse; d=2 -> set skip_err, step_count unchanged, no pulse; in every case the stored quadrant becomes q.
REQ-022 SHALL, in TRACK, leave the stored quadrant and step_count unchanged on accepted codes without a quadrant (coil off or short).
REQ-023 SHALL have step_pulse, step_count and dir update one clock after acceptance, i.e. GLITCH_CYCLES+3 clocks after a clean pin change (2 synchronizer clocks + filter + 1 register).
REQ-024 SHALL wrap step_count two's-complement at the COUNT_W boundary with no saturation.
REQ-025 SHALL use a free-running window counter 0..PWM_WINDOW-1 together with per-channel high counters.
REQ-026 SHALL, in the clock where the window counter is PWM_WINDOW-1, latch duty_a and duty_b with that clock's sample included, pulse duty_valid, and restart the high counters.
REQ-027 SHALL handle the full-scale case: a VREF held high for the whole window gives duty = PWM_WINDOW.
REQ-028 SHALL give clr_flags priority for that clock: skip_err and fault are cleared unless set again in the same clock, in which case set wins.
REQ-029 SHALL leave step_count, the FSM and the duty logic unaffected by clr_flags.

Reset
REQ-030 SHALL, while resetn_in=0, hold these reset values: step_count=0, dir=0, step_pulse=0, skip_err=0, fault=0, duty_a=0, duty_b=0, duty_valid=0, synchronizers, filter and window counter=0, FSM=INIT.
REQ-031 SHALL, on reset asserted mid-operation, reset immediately and drop any partially filtered code.
REQ-032 SHALL, after reset release, start the first duty window from 0.

Verification
REQ-033 SHALL cover forward sequence: from reset drive quadrants 0,1,2,3,0 held 20 clocks each -> step_count=4, dir=1, exactly 4 step_pulses, skip_err=0.
REQ-034 SHALL cover reverse and wrap: after INIT at quadrant 0 drive quadrants 3,2,1,0 -> step_count=-4 (all ones minus 3), dir=0, exactly 4 step_pulses.
REQ-035 SHALL cover glitch rejection: a 3-clock PHASE_A1 pulse with GLITCH_CYCLES=4 -> no step_pulse and step_count unchanged; a 6-clock pulse -> change accepted.
REQ-036 SHALL cover skip and fault: jump quadrant 0 -> 2 -> skip_err=1 and count unchanged; drive A1=A2=1 for 10 clocks -> fault=1; pulse clr_flags -> both flags 0.
REQ-037 SHALL cover duty measurement: VREF_A 25% square at period 16 and VREF_B held high, PWM_WINDOW=256 -> second duty_valid gives duty_a=64 and duty_b=256.
REQ-038 SHALL cover reset mid-move: assert resetn_in=0 while in TRACK -> all outputs 0 immediately; after release the first valid quadrant re-enters TRACK with no step_pulse.
